// File: rtl/m_unit_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : m_unit_seq_if
// Description : Co-processor handshake bundle between the core (master) and
//               the sequential multiply/divide unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface m_unit_seq_if #(
  parameter int XLEN = 32
);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_busy;
  logic            pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready
  );
endinterface
`default_nettype wire

// File: rtl/m_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : m_unit_seq
// Description : Sequential RV M-extension unit. Pipelined multiplier with
//               MUL_LAT stages and a restoring divider that retires DIV_STEP
//               quotient bits per cycle, followed by a one-cycle sign fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
module m_unit_seq #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1,
  parameter int MUL_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  m_unit_seq_if.slave bus
);

  localparam int              C_N_ITER   = XLEN / DIV_STEP;
  localparam int              C_CW       = $clog2(C_N_ITER) + 1;
  localparam logic [C_CW-1:0] C_LAST_DIV = C_CW'(C_N_ITER - 1);
  localparam logic [C_CW-1:0] C_LAST_MUL = C_CW'(MUL_LAT - 1);
  localparam logic [XLEN-1:0] C_MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            armed_q, armed_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] op_a_q, op_a_d;      // multiplicand, or dividend/quotient shift register
  logic [XLEN-1:0] op_b_q, op_b_d;      // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;        // partial remainder
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;

  // ---------------------------------------------------------------------------
  // Instruction decode and operand conditioning in the accept cycle
  // ---------------------------------------------------------------------------
  logic            insn_match, accept;
  logic [2:0]      in_funct3;
  logic            in_is_div, in_is_rem, in_signed_div;
  logic            in_a_neg, in_b_neg, in_div_zero, in_overflow;
  logic [XLEN-1:0] in_a_mag, in_b_mag;
  logic            unused_insn_bits;

  assign in_funct3     = bus.pcpi_insn[14:12];
  assign insn_match    = (bus.pcpi_insn[6:0] == 7'b0110011) && (bus.pcpi_insn[31:25] == 7'b0000001);
  // Reset wins over a same-cycle accept.
  assign accept        = (state_q == S_IDLE) && bus.pcpi_valid && armed_q && insn_match && !reset;
  assign in_is_div     = in_funct3[2];
  assign in_is_rem     = in_funct3[1];
  assign in_signed_div = in_is_div && !in_funct3[0];
  assign in_a_neg      = in_signed_div && bus.pcpi_rs1[XLEN-1];
  assign in_b_neg      = in_signed_div && bus.pcpi_rs2[XLEN-1];
  assign in_a_mag      = in_a_neg ? -bus.pcpi_rs1 : bus.pcpi_rs1;
  assign in_b_mag      = in_b_neg ? -bus.pcpi_rs2 : bus.pcpi_rs2;
  assign in_div_zero   = (bus.pcpi_rs2 == '0);
  assign in_overflow   = in_signed_div && (bus.pcpi_rs1 == C_MIN_INT) && (bus.pcpi_rs2 == '1);
  assign unused_insn_bits = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7]};

  // ---------------------------------------------------------------------------
  // Multiplier: operands widened with per-funct3 sign so one signed multiply
  // covers MUL/MULH/MULHSU/MULHU.
  // ---------------------------------------------------------------------------
  logic                   a_signed_mul, b_signed_mul;
  logic signed [2*XLEN+1:0] mul_a_ext, mul_b_ext, mul_full;
  logic [2*XLEN-1:0]      mul_prod, mul_out;
  logic                   unused_mul_bits;

  assign a_signed_mul    = (funct3_q != 3'b011);
  assign b_signed_mul    = !funct3_q[1];
  assign mul_a_ext       = {{(XLEN+2){a_signed_mul & op_a_q[XLEN-1]}}, op_a_q};
  assign mul_b_ext       = {{(XLEN+2){b_signed_mul & op_b_q[XLEN-1]}}, op_b_q};
  assign mul_full        = mul_a_ext * mul_b_ext;
  assign mul_prod        = mul_full[2*XLEN-1:0];
  assign unused_mul_bits = ^mul_full[2*XLEN+1:2*XLEN];

  generate
    if (MUL_LAT == 1) begin : g_mul_direct
      assign mul_out = mul_prod;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] pipe_q [MUL_LAT-1];
      logic [2*XLEN-1:0] pipe_d [MUL_LAT-1];

      // Shift the product through the extra multiplier stages
      always_comb begin
        pipe_d[0] = mul_prod;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // Multiplier pipeline registers
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MUL_LAT - 1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < MUL_LAT - 1; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign mul_out = pipe_q[MUL_LAT-2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Restoring divide: DIV_STEP shift/compare/subtract steps per cycle
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   div_r;
  logic [XLEN-1:0] div_q;

  // Unrolled restoring-division steps on the magnitudes
  always_comb begin
    div_r = {1'b0, rem_q};
    div_q = op_a_q;
    for (int j = 0; j < DIV_STEP; j++) begin
      div_r = {div_r[XLEN-1:0], div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], 1'b0};
      if (div_r >= {1'b0, op_b_q}) begin
        div_r    = div_r - {1'b0, op_b_q};
        div_q[0] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping pcpi_valid mid-operation abandons it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_is_div && (in_div_zero || in_overflow)) state_d = S_DONE;
          else if (in_is_div)                            state_d = S_DIV;
          else                                           state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (!bus.pcpi_valid)          state_d = S_IDLE;
        else if (cnt_q == C_LAST_MUL) state_d = S_DONE;
      end
      S_DIV: begin
        if (!bus.pcpi_valid)          state_d = S_IDLE;
        else if (cnt_q == C_LAST_DIV) state_d = S_FIX;
      end
      S_FIX: begin
        if (!bus.pcpi_valid) state_d = S_IDLE;
        else                 state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; rd is only driven during the completion cycle
  always_comb begin
    bus.pcpi_ready = (state_q == S_DONE);
    bus.pcpi_wr    = (state_q == S_DONE);
    bus.pcpi_rd    = (state_q == S_DONE) ? result_q : '0;
    bus.pcpi_busy  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX) || accept;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Datapath next-state: latch at accept, iterate, fix signs, hold result
  always_comb begin
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rem_d     = rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          funct3_d  = in_funct3;
          op_a_d    = in_is_div ? in_a_mag : bus.pcpi_rs1;
          op_b_d    = in_is_div ? in_b_mag : bus.pcpi_rs2;
          rem_d     = '0;
          quo_neg_d = in_a_neg ^ in_b_neg;
          rem_neg_d = in_a_neg;
          if (in_is_div && in_div_zero) begin
            result_d = in_is_rem ? bus.pcpi_rs1 : '1;
          end else if (in_is_div && in_overflow) begin
            result_d = in_is_rem ? '0 : bus.pcpi_rs1;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_MUL) begin
          result_d = (funct3_q == 3'b000) ? mul_out[XLEN-1:0] : mul_out[2*XLEN-1:XLEN];
        end
      end
      S_DIV: begin
        cnt_d  = cnt_q + 1'b1;
        op_a_d = div_q;
        rem_d  = div_r[XLEN-1:0];
      end
      S_FIX: begin
        if (funct3_q[1]) result_d = rem_neg_q ? -rem_q  : rem_q;
        else             result_d = quo_neg_q ? -op_a_q : op_a_q;
      end
      default: ;
    endcase
  end

  // Re-arm whenever valid drops; disarm on completion so a held request is
  // not accepted a second time.
  always_comb begin
    armed_d = armed_q;
    if (!bus.pcpi_valid)                             armed_d = 1'b1;
    else if (state_d == S_DONE && state_q != S_DONE) armed_d = 1'b0;
  end

  // Datapath and arming registers
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q   <= 1'b1;
      cnt_q     <= '0;
      funct3_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rem_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rem_q     <= rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_unit_seq
// Description : Directed self-checking bench for m_unit_seq (DIV_STEP=1 and
//               DIV_STEP=4 instances, XLEN=32, MUL_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_unit_seq;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  m_unit_seq_if #(.XLEN(32)) bus_a ();
  m_unit_seq_if #(.XLEN(32)) bus_b ();

  m_unit_seq #(.XLEN(32), .DIV_STEP(1), .MUL_LAT(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  m_unit_seq #(.XLEN(32), .DIV_STEP(4), .MUL_LAT(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic drive(input bit use_b, input logic v, input logic [31:0] insn,
                       input logic [31:0] a, input logic [31:0] b);
    if (use_b) begin
      bus_b.pcpi_valid = v; bus_b.pcpi_insn = insn; bus_b.pcpi_rs1 = a; bus_b.pcpi_rs2 = b;
    end else begin
      bus_a.pcpi_valid = v; bus_a.pcpi_insn = insn; bus_a.pcpi_rs1 = a; bus_a.pcpi_rs2 = b;
    end
  endtask

  // Issue one op starting in the current cycle T, wait for ready (bounded),
  // then drop valid for one cycle. lat = cycles after T, -1 on timeout.
  task automatic run_op(input bit use_b, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] rd, output int lat,
                        output logic bsy, output logic wr, output logic [31:0] pre);
    drive(use_b, 1'b1, mk(f3), a, b);
    lat = -1; rd = '0; wr = 1'b0; pre = '0; bsy = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k == 0) bsy = use_b ? bus_b.pcpi_busy : bus_a.pcpi_busy;
      if (use_b ? bus_b.pcpi_ready : bus_a.pcpi_ready) begin
        lat = k;
        rd  = use_b ? bus_b.pcpi_rd : bus_a.pcpi_rd;
        wr  = use_b ? bus_b.pcpi_wr : bus_a.pcpi_wr;
        break;
      end
      pre |= use_b ? bus_b.pcpi_rd : bus_a.pcpi_rd;
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
    drive(use_b, 1'b0, mk(f3), a, b);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus_a.pcpi_wr, bus_a.pcpi_ready, bus_a.pcpi_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got wr/ready/busy=%b want 000",
               {bus_a.pcpi_wr, bus_a.pcpi_ready, bus_a.pcpi_busy});
    end
    checks++;
    if (bus_a.pcpi_rd !== 32'h0) begin
      errors++; $display("FAIL reset_rd got %h want 00000000", bus_a.pcpi_rd);
    end
    checks++;
    if ({bus_b.pcpi_ready, bus_b.pcpi_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_b got ready/busy=%b want 00", {bus_b.pcpi_ready, bus_b.pcpi_busy});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [7];
    logic [31:0] av [7], bv [7], ev [7];
    logic [31:0] rd, pre;
    int          lat;
    logic        bsy, wr;
    f3 = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd0, 3'd1, 3'd2};
    av = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 32'd2};
    bv = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd5, 32'h80000000};
    ev = '{32'h40000000, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFF, 32'h00000001};
    for (int i = 0; i < 7; i++) begin
      run_op(0, f3[i], av[i], bv[i], rd, lat, bsy, wr, pre);
      checks++;
      if (rd !== ev[i]) begin errors++; $display("FAIL mul_rd[%0d] got %h want %h", i, rd, ev[i]); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL mul_lat[%0d] got %0d want 2", i, lat); end
      checks++;
      if (bsy !== 1'b1 || wr !== 1'b1 || pre !== 32'h0) begin
        errors++; $display("FAIL mul_hs[%0d] got busy=%b wr=%b pre_rd=%h want 1 1 0", i, bsy, wr, pre);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [8];
    logic [31:0] av [8], bv [8], ev [8];
    logic [31:0] rd, pre;
    int          lat;
    logic        bsy, wr;
    f3 = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
    av = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    bv = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'd2};
    ev = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'h7FFFFFFC, 32'd1};
    for (int i = 0; i < 8; i++) begin
      run_op(0, f3[i], av[i], bv[i], rd, lat, bsy, wr, pre);
      checks++;
      if (rd !== ev[i]) begin errors++; $display("FAIL div_rd[%0d] got %h want %h", i, rd, ev[i]); end
      checks++;
      if (lat !== 34) begin errors++; $display("FAIL div_lat[%0d] got %0d want 34", i, lat); end
      checks++;
      if (bsy !== 1'b1 || wr !== 1'b1 || pre !== 32'h0) begin
        errors++; $display("FAIL div_hs[%0d] got busy=%b wr=%b pre_rd=%h want 1 1 0", i, bsy, wr, pre);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [5];
    logic [31:0] av [5], bv [5], ev [5];
    logic [31:0] rd, pre;
    int          lat;
    logic        bsy, wr;
    f3 = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd6};
    av = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
    bv = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    ev = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFF9};
    for (int i = 0; i < 5; i++) begin
      run_op(0, f3[i], av[i], bv[i], rd, lat, bsy, wr, pre);
      checks++;
      if (rd !== ev[i]) begin errors++; $display("FAIL special_rd[%0d] got %h want %h", i, rd, ev[i]); end
      checks++;
      if (lat !== 1 || bsy !== 1'b1) begin
        errors++; $display("FAIL special_lat[%0d] got lat=%0d busy=%b want 1 1", i, lat, bsy);
      end
    end
  endtask

  task automatic test_div_step4();
    logic [2:0]  f3 [3];
    logic [31:0] av [3], bv [3], ev [3];
    logic [31:0] rd, pre;
    int          lat;
    logic        bsy, wr;
    f3 = '{3'd4, 3'd6, 3'd5};
    av = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100};
    bv = '{32'd2, 32'd2, 32'd7};
    ev = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
    for (int i = 0; i < 3; i++) begin
      run_op(1, f3[i], av[i], bv[i], rd, lat, bsy, wr, pre);
      checks++;
      if (rd !== ev[i]) begin errors++; $display("FAIL div4_rd[%0d] got %h want %h", i, rd, ev[i]); end
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL div4_lat[%0d] got %0d want 10", i, lat); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, pre;
    int          lat, nrdy;
    logic        bsy, wr;
    drive(0, 1'b1, mk(3'd4), 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    bus_a.pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.pcpi_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_t10 got %b want 1", bus_a.pcpi_busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_a.pcpi_busy !== 1'b0 || bus_a.pcpi_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b ready=%b want 0 0", bus_a.pcpi_busy, bus_a.pcpi_ready);
    end
    nrdy = 0;
    repeat (40) begin @(negedge clk); if (bus_a.pcpi_ready || bus_a.pcpi_wr) nrdy++; end
    checks++;
    if (nrdy !== 0) begin errors++; $display("FAIL abort_no_ready got %0d strobes want 0", nrdy); end
    @(posedge clk); #1;
    run_op(0, 3'd0, 32'd3, 32'd4, rd, lat, bsy, wr, pre);
    checks++;
    if (rd !== 32'd12 || lat !== 2) begin
      errors++; $display("FAIL abort_next_mul got rd=%h lat=%0d want 0000000c 2", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, rdh, pre;
    int          lat, nrdy;
    logic        bsy, wr;
    drive(0, 1'b1, mk(3'd0), 32'd3, 32'd4);
    nrdy = 0; rdh = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus_a.pcpi_ready) begin nrdy++; rdh = bus_a.pcpi_rd; end
      @(posedge clk); #1;
      bus_a.pcpi_rs1 = 32'd5;
      bus_a.pcpi_rs2 = 32'd6;
    end
    checks++;
    if (nrdy !== 1) begin errors++; $display("FAIL hold_ready_count got %0d want 1", nrdy); end
    checks++;
    if (rdh !== 32'd12) begin errors++; $display("FAIL hold_latched_rd got %h want 0000000c", rdh); end
    bus_a.pcpi_valid = 1'b0;
    @(posedge clk); #1;
    run_op(0, 3'd5, 32'd100, 32'd7, rd, lat, bsy, wr, pre);
    checks++;
    if (rd !== 32'd14 || lat !== 34) begin
      errors++; $display("FAIL rearm_divu got rd=%h lat=%0d want 0000000e 34", rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    int nrdy;
    drive(0, 1'b1, mk(3'd4), 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    bus_a.pcpi_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_a.pcpi_busy, bus_a.pcpi_ready, bus_a.pcpi_wr} !== 3'b000 || bus_a.pcpi_rd !== 32'h0) begin
      errors++; $display("FAIL rstmid_out got busy/ready/wr=%b rd=%h want 000 00000000",
                         {bus_a.pcpi_busy, bus_a.pcpi_ready, bus_a.pcpi_wr}, bus_a.pcpi_rd);
    end
    nrdy = 0;
    repeat (40) begin @(negedge clk); if (bus_a.pcpi_ready) nrdy++; end
    checks++;
    if (nrdy !== 0) begin errors++; $display("FAIL rstmid_no_ready got %0d want 0", nrdy); end
    @(posedge clk); #1;
    // Reset coincident with a valid request must not start it.
    reset = 1'b1;
    drive(0, 1'b1, mk(3'd0), 32'd3, 32'd4);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_a.pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.pcpi_busy !== 1'b0) begin errors++; $display("FAIL rst_priority_busy got %b want 0", bus_a.pcpi_busy); end
    @(negedge clk);
    checks++;
    if (bus_a.pcpi_ready !== 1'b0) begin errors++; $display("FAIL rst_priority_ready got %b want 0", bus_a.pcpi_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_nonmatch();
    logic [31:0] insns [2];
    int          bad;
    insns = '{{7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011},
              {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0010011}};
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, insns[i], 32'd3, 32'd4);
      bad = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus_a.pcpi_busy || bus_a.pcpi_ready || bus_a.pcpi_wr || (bus_a.pcpi_rd != 32'h0)) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL nonmatch[%0d] got %0d active cycles want 0", i, bad); end
      @(posedge clk); #1;
      bus_a.pcpi_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_div_step4();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_nonmatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/m_unit_seq.md
M_UNIT_SEQ -- requirements
Module: m_unit_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (32 or 64).
REQ-002 SHALL have parameter DIV_STEP, default 1, quotient bits per divide cycle (1, 2 or 4; SHALL divide XLEN).
REQ-003 SHALL have parameter MUL_LAT, default 1, multiplier pipeline stages (1..3).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pcpi_valid  input  1  core presents a candidate instruction.
REQ-007 SHALL have port pcpi_insn  input  32  instruction word.
REQ-008 SHALL have port pcpi_rs1  input  XLEN  operand A (dividend / multiplicand).
REQ-009 SHALL have port pcpi_rs2  input  XLEN  operand B (divisor / multiplier).
REQ-010 SHALL have port pcpi_wr  output  1  result writes rd.
REQ-011 SHALL have port pcpi_rd  output  XLEN  result.
REQ-012 SHALL have port pcpi_busy  output  1  operation in progress.
REQ-013 SHALL have port pcpi_ready  output  1  one-cycle completion strobe.

Function
REQ-014 SHALL accept when state is IDLE, pcpi_valid=1, armed=1, opcode=0110011 and funct7=0000001; funct3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
REQ-015 SHALL latch funct3, rs1 and rs2 in the accept cycle T; later changes on pcpi_rs1/pcpi_rs2 have no effect.
REQ-016 SHALL implement states IDLE, MUL, DIV, FIX, DONE; IDLE->MUL for multiply, IDLE->DIV for divide/remainder, IDLE->DONE for special cases (REQ-021, REQ-022).
REQ-017 MUL: 2*XLEN product, signed/unsigned per operand as funct3 dictates; MUL returns low XLEN bits, others return high XLEN bits; state MUL for MUL_LAT cycles, then DONE; pcpi_ready at T+MUL_LAT+1.
REQ-018 DIV: restoring division on magnitudes (signed ops negate negative operands at accept); DIV_STEP quotient bits per cycle for XLEN/DIV_STEP cycles; iteration counter width clog2(XLEN/DIV_STEP)+1.
REQ-019 FIX: one cycle; DIV negates quotient iff operand signs differ; REM negates remainder iff dividend negative; unsigned ops pass through.
REQ-020 Divide latency: pcpi_ready at T+XLEN/DIV_STEP+2.
REQ-021 Divide by zero (rs2=0): DIV/DIVU -> all ones, REM/REMU -> rs1; pcpi_ready at T+1.
REQ-022 Signed overflow (DIV/REM, rs1=1<<(XLEN-1), rs2=all ones): DIV -> rs1, REM -> 0; pcpi_ready at T+1.
REQ-023 DONE: pcpi_ready=1, pcpi_wr=1, pcpi_rd=result for exactly one cycle, then IDLE; pcpi_rd=0 in all other cycles.
REQ-024 pcpi_busy=1 in MUL, DIV and FIX, and in the accept cycle; pcpi_busy=0 in DONE and in non-accepting IDLE cycles.
REQ-025 Abort: pcpi_valid=0 in MUL, DIV or FIX -> IDLE next cycle; no pcpi_ready and no pcpi_wr for that operation.
REQ-026 armed flag SHALL be cleared on entering DONE and set in any cycle with pcpi_valid=0; this prevents re-accepting the same instruction in the cycle after pcpi_ready.
REQ-027 Non-matching instructions SHALL be ignored: stay IDLE with all outputs 0.

Reset
REQ-028 When reset=1 at a rising edge: state IDLE, armed=1, counter 0, operand/result registers 0; pcpi_wr, pcpi_ready and pcpi_busy 0 and pcpi_rd 0 from the next cycle.
REQ-029 reset SHALL override any in-flight operation with no completion strobe, and SHALL take priority over a simultaneous accept.

Verification (XLEN=32, DIV_STEP=1, MUL_LAT=1 unless stated)
REQ-030 MULH 0x80000000 x 0x80000000 -> pcpi_rd=0x40000000 at T+2; MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001; MULHU of the same operands -> 0xFFFFFFFE.
REQ-031 DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each at T+34; with DIV_STEP=4, same results at T+10.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005, at T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same -> 0, at T+1.
REQ-033 pcpi_valid dropped at T+10 of a DIV -> no pcpi_ready, IDLE at T+11; a following MUL 3x4 -> 12.
REQ-034 pcpi_valid held high with the same instruction across pcpi_ready -> exactly one pcpi_ready; reset asserted at T+5 of a DIV -> outputs 0 and no pcpi_ready ever.
REQ-035 Random signed/unsigned operands across XLEN=32/64 and DIV_STEP=1/2/4 -> results match a reference model, latency exactly per REQ-017, REQ-020, REQ-021 and REQ-022.
